// File: rtl/seq_datapath.sv
// Multi-cycle register-file / ALU / shifter datapath.
// Each accepted micro-op runs IDLE -> READ -> EXEC -> WRITE, one stage per clock.
module seq_datapath #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [1:0]            cmd_shift,
  input  logic [ADDR_WIDTH-1:0] cmd_wa,
  input  logic [ADDR_WIDTH-1:0] cmd_raa,
  input  logic [ADDR_WIDTH-1:0] cmd_rab,
  input  logic [DATA_WIDTH-1:0] Inport,
  output logic [DATA_WIDTH-1:0] Outport,
  output logic                  out_valid,
  output logic                  Zero,
  output logic                  Carry,
  output logic [1:0]            dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready.
  // cmd_ready depends only on state and reset, never on cmd_valid.

  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_SHL  = 2'b01;
  localparam logic [1:0] SH_SHR  = 2'b10;
  localparam logic [1:0] SH_ROR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            op_q;
  logic [1:0]            shift_q;
  logic [ADDR_WIDTH-1:0] wa_q, raa_q, rab_q;
  logic [DATA_WIDTH-1:0] in_q, a_q, b_q, res_q;
  logic [DATA_WIDTH-1:0] regs_q [DEPTH];
  logic [DATA_WIDTH-1:0] outport_q;
  logic                  out_valid_q, zero_q, carry_q;

  logic [DATA_WIDTH:0]   alu;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] res_d;
  logic                  zero_d, carry_d, flag_upd;

  assign cmd_ready = (state_q == S_IDLE) && RSTn;
  assign Outport   = outport_q;
  assign out_valid = out_valid_q;
  assign Zero      = zero_q;
  assign Carry     = carry_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_valid && cmd_ready) state_d = S_READ;
      S_READ:  state_d = S_EXEC;
      S_EXEC:  state_d = S_WRITE;
      S_WRITE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ALU is one bit wider than the data so bit DATA_WIDTH carries ADD carry / SUB borrow.
  always_comb begin
    alu      = '0;
    flag_upd = 1'b1;
    case (op_q)
      OP_ADD:  alu = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB:  alu = {1'b0, a_q} - {1'b0, b_q};
      OP_AND:  alu = {1'b0, a_q & b_q};
      OP_OR:   alu = {1'b0, a_q | b_q};
      OP_XOR:  alu = {1'b0, a_q ^ b_q};
      OP_PASS: alu = {1'b0, a_q};
      default: flag_upd = 1'b0;
    endcase

    shifted = alu[DATA_WIDTH-1:0];
    case (shift_q)
      SH_NONE: shifted = alu[DATA_WIDTH-1:0];
      SH_SHL:  shifted = {alu[DATA_WIDTH-2:0], 1'b0};
      SH_SHR:  shifted = {1'b0, alu[DATA_WIDTH-1:1]};
      SH_ROR:  shifted = {alu[0], alu[DATA_WIDTH-1:1]};
      default: shifted = alu[DATA_WIDTH-1:0];
    endcase

    res_d   = (op_q == OP_LOAD) ? in_q : shifted;
    zero_d  = (shifted == '0);
    carry_d = ((op_q == OP_ADD) || (op_q == OP_SUB)) ? alu[DATA_WIDTH] : 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q     <= S_IDLE;
      op_q        <= OP_NOP;
      shift_q     <= SH_NONE;
      wa_q        <= '0;
      raa_q       <= '0;
      rab_q       <= '0;
      in_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      outport_q   <= '0;
      out_valid_q <= 1'b0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            op_q    <= cmd_op;
            shift_q <= cmd_shift;
            wa_q    <= cmd_wa;
            raa_q   <= cmd_raa;
            rab_q   <= cmd_rab;
            in_q    <= Inport;
          end
        end
        S_READ: begin
          a_q <= regs_q[raa_q];
          b_q <= regs_q[rab_q];
        end
        S_EXEC: begin
          res_q <= res_d;
          if (flag_upd) begin
            zero_q  <= zero_d;
            carry_q <= carry_d;
          end
        end
        S_WRITE: begin
          if (op_q != OP_NOP) begin
            regs_q[wa_q] <= res_q;
            outport_q    <= res_q;
            out_valid_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_datapath.sv
// Bench for seq_datapath: directed and random micro-ops, scoreboard fed by an
// arithmetic reference model, monitor checking each completion pulse.
module tb_seq_datapath;

  localparam int W  = 8;
  localparam int AW = 3;

  // clock / reset
  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [1:0]    cmd_shift = '0;
  logic [AW-1:0] cmd_wa = '0, cmd_raa = '0, cmd_rab = '0;
  logic [W-1:0]  Inport = '0;
  logic [W-1:0]  Outport;
  logic          out_valid, Zero, Carry;
  logic [1:0]    dbg_state;

  always #5 CLK = ~CLK;

  seq_datapath #(.DATA_WIDTH(W), .ADDR_WIDTH(AW)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_shift(cmd_shift),
    .cmd_wa(cmd_wa), .cmd_raa(cmd_raa), .cmd_rab(cmd_rab),
    .Inport(Inport), .Outport(Outport), .out_valid(out_valid),
    .Zero(Zero), .Carry(Carry), .dbg_state(dbg_state)
  );

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  bit rst_seen = 1'b0;
  always @(posedge CLK) rst_seen <= !RSTn;

  // scoreboard: {result, zero, carry} and the cycle the pulse is due
  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W+1:0] exp_q[$];
  int           cyc_q[$];
  logic [W-1:0] last_out = '0;

  // reference model state
  int m_r[8];
  bit m_z = 1'b0, m_c = 1'b0;
  int last_acc = -100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_r[i] = 0;
    m_z = 1'b0;
    m_c = 1'b0;
    last_out = '0;
  endtask

  // Predict one command from the rules: arithmetic on ints, shifts as *2, /2.
  task automatic model_apply(input logic [2:0] op, input logic [1:0] sh, input logic [2:0] wa,
                             input logic [2:0] raa, input logic [2:0] rab, input logic [7:0] din);
    int a, b, v, s, res;
    bit upd, nc;
    logic [7:0] r8;
    a = m_r[raa];
    b = m_r[rab];
    v = 0;
    upd = 1'b1;
    nc = 1'b0;
    case (op)
      3'd2: begin v = a + b; nc = (v >= 256); end
      3'd3: begin v = a - b; nc = (a < b); if (v < 0) v = v + 256; end
      3'd4: v = a & b;
      3'd5: v = a | b;
      3'd6: v = a ^ b;
      3'd7: v = a;
      default: upd = 1'b0;
    endcase
    v = v % 256;
    case (sh)
      2'd1: s = (v * 2) % 256;
      2'd2: s = v / 2;
      2'd3: s = v / 2 + (v % 2) * 128;
      default: s = v;
    endcase
    res = (op == 3'd1) ? int'(din) : s;
    if (upd) begin
      m_z = (s == 0);
      m_c = nc;
    end
    if (op != 3'd0) begin
      m_r[wa] = res;
      r8 = res[7:0];
      exp_q.push_back({r8, m_z, m_c});
      cyc_q.push_back(cyc + 4);
    end
  endtask

  // driver: present a command, wait (bounded) for cmd_ready, then scramble inputs
  task automatic send(input logic [2:0] op, input logic [1:0] sh, input logic [2:0] wa,
                      input logic [2:0] raa, input logic [2:0] rab, input logic [7:0] din,
                      input bit track, input bit keep_valid, input bit chk_gap);
    int waited = 0;
    @(negedge CLK);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_shift = sh;
    cmd_wa    = wa;
    cmd_raa   = raa;
    cmd_rab   = rab;
    Inport    = din;
    while (!cmd_ready) begin
      if (waited > 20) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ready_timeout: cmd_ready low for %0d cycles, expected high within 20", waited);
        cmd_valid = 1'b0;
        return;
      end
      @(negedge CLK);
      waited++;
    end
    if (chk_gap) check("accept_gap", cyc - last_acc, 4);
    last_acc = cyc;
    if (track) model_apply(op, sh, wa, raa, rab, din);
    @(posedge CLK);
    #1;
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_shift = 2'($urandom_range(0, 3));
    cmd_wa    = 3'($urandom_range(0, 7));
    cmd_raa   = 3'($urandom_range(0, 7));
    cmd_rab   = 3'($urandom_range(0, 7));
    Inport    = 8'($urandom_range(0, 255));
    if (!keep_valid) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d completions outstanding, expected 0", exp_q.size());
      exp_q.delete();
      cyc_q.delete();
    end
  endtask

  // monitor
  always @(negedge CLK) begin
    logic [W+1:0] e;
    int           c;
    if (rst_seen) last_out = '0;
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_out_valid: got pulse with Outport=%0h, expected none", Outport);
      end else begin
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("outport", Outport, e[W+1:2]);
        check("zero", Zero, e[1]);
        check("carry", Carry, e[0]);
        check("latency", cyc, c);
        last_out = e[W+1:2];
      end
    end else if (RSTn) begin
      check("outport_hold", Outport, last_out);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_clear();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check("rst_outport", Outport, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_zero", Zero, 0);
    check("rst_carry", Carry, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    @(posedge CLK);
    #1 RSTn = 1'b1;
    @(negedge CLK);
    check("ready_after_reset", cmd_ready, 1);

    // directed arithmetic
    send(3'd1, 2'd0, 3'd1, 3'd0, 3'd0, 8'h0F, 1, 0, 0);
    send(3'd1, 2'd0, 3'd2, 3'd0, 3'd0, 8'hF1, 1, 0, 0);
    send(3'd2, 2'd0, 3'd3, 3'd1, 3'd2, 8'h00, 1, 0, 0);
    drain();
    check("add_out", Outport, 8'h00);
    check("add_zero", Zero, 1);
    check("add_carry", Carry, 1);
    send(3'd3, 2'd0, 3'd4, 3'd1, 3'd2, 8'h00, 1, 0, 0);
    drain();
    check("sub_out", Outport, 8'h1E);
    check("sub_carry", Carry, 1);
    check("sub_zero", Zero, 0);
    send(3'd3, 2'd0, 3'd5, 3'd2, 3'd1, 8'h00, 1, 0, 0);
    drain();
    check("sub2_out", Outport, 8'hE2);
    check("sub2_carry", Carry, 0);
    send(3'd7, 2'd1, 3'd6, 3'd2, 3'd0, 8'h00, 1, 0, 0);
    drain();
    check("shl_out", Outport, 8'hE2);
    send(3'd7, 2'd2, 3'd7, 3'd2, 3'd0, 8'h00, 1, 0, 0);
    drain();
    check("shr_out", Outport, 8'h78);
    send(3'd7, 2'd3, 3'd0, 3'd2, 3'd0, 8'h00, 1, 0, 0);
    drain();
    check("ror_out", Outport, 8'hF8);
    check("ror_carry", Carry, 0);

    // back-to-back with cmd_valid held, including a NOP
    send(3'd2, 2'd0, 3'd1, 3'd1, 3'd2, 8'h00, 1, 1, 0);
    send(3'd6, 2'd3, 3'd2, 3'd1, 3'd1, 8'h00, 1, 1, 1);
    send(3'd0, 2'd1, 3'd3, 3'd1, 3'd2, 8'h55, 1, 1, 1);
    send(3'd4, 2'd2, 3'd3, 3'd3, 3'd4, 8'h00, 1, 1, 1);
    send(3'd1, 2'd3, 3'd3, 3'd0, 3'd0, 8'h3C, 1, 1, 1);
    send(3'd0, 2'd0, 3'd3, 3'd3, 3'd3, 8'h00, 1, 0, 1);
    drain();

    // reset while LOAD R6=0xAA is in EXEC
    send(3'd1, 2'd0, 3'd6, 3'd0, 3'd0, 8'hAA, 0, 0, 0);
    @(posedge CLK);
    #1 RSTn = 1'b0;
    @(negedge CLK);
    check("ready_in_reset", cmd_ready, 0);
    @(posedge CLK);
    #1 RSTn = 1'b1;
    model_clear();
    send(3'd7, 2'd0, 3'd7, 3'd6, 3'd0, 8'h00, 1, 0, 0);
    drain();
    check("r6_after_reset", Outport, 8'h00);
    check("r6_zero", Zero, 1);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      bit keep;
      keep = 1'($urandom_range(0, 1));
      send(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)),
           1, keep, 0);
      if (!keep) repeat ($urandom_range(0, 5)) @(posedge CLK);
    end
    cmd_valid = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_datapath.md
Name: seq_datapath

Overview:
- Parametrised, multi-cycle successor to the lab register-file/ALU/shifter datapath.
- Accepts one micro-op per valid/ready handshake and executes it through a registered READ→EXEC→WRITE sequence.
- Adds generic depth, ALU/shift modes and Zero/Carry flags.
- Sits between the lab control FSM (or testbench sequencer) and the board I/O (Inport/Outport).

Parameters:
- DATA_WIDTH, 8, width of registers, ALU, Inport and Outport.
- ADDR_WIDTH, 3, register address width; register file depth = 2**ADDR_WIDTH.

Ports:
- CLK  in  1  single clock, rising edge.
- RSTn  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  operation: 000 NOP, 001 LOAD, 010 ADD, 011 SUB, 100 AND, 101 OR, 110 XOR, 111 PASS A.
- cmd_shift  in  2  post-ALU shift: 00 none, 01 SHL1, 10 SHR1 logical, 11 ROR1.
- cmd_wa  in  ADDR_WIDTH  destination register.
- cmd_raa  in  ADDR_WIDTH  operand A register.
- cmd_rab  in  ADDR_WIDTH  operand B register.
- Inport  in  DATA_WIDTH  load data.
- Outport  out  DATA_WIDTH  last completed result.
- out_valid  out  1  one-cycle completion pulse.
- Zero  out  1  last ALU result was zero.
- Carry  out  1  ADD carry-out / SUB borrow.

Behaviour:
- Clock/reset: one clock CLK; reset RSTn is synchronous, active-low.
- Reset (RSTn=0 at a rising edge):
  - state←IDLE; all registers R[0..depth-1]←0.
  - Outport←0, out_valid←0, Zero←0, Carry←0.
  - cmd_ready=0 while RSTn=0.
- States: IDLE, READ, EXEC, WRITE.
- cmd_ready = (state==IDLE) && RSTn. Combinational from state only; never depends on cmd_valid.
- IDLE: on an edge with cmd_valid && cmd_ready:
  - latch op, shift, wa, raa, rab and Inport into the command register.
  - go to READ.
  - Otherwise stay in IDLE.
- READ: A←R[raa], B←R[rab] (registered); go to EXEC.
- EXEC: compute the result into the result register; go to WRITE.
  - LOAD: result = latched Inport, no shift.
  - ALU ops: (DATA_WIDTH+1)-bit arithmetic.
    - ADD: Carry = bit DATA_WIDTH of A+B.
    - SUB: A−B; Carry = 1 iff A<B (unsigned borrow).
  - Shift is then applied to the ALU output. SHL1/SHR1 shift in 0; ROR1 moves bit 0 to the MSB.
  - Zero = (final shifted result == 0).
  - Flags update only for ADD..PASS. Carry←0 for AND/OR/XOR/PASS. Flags hold for NOP/LOAD.
- WRITE:
  - If op≠NOP: R[wa]←result, Outport←result, out_valid←1 for exactly one cycle.
  - NOP: no write; Outport holds; out_valid stays 0.
  - Go to IDLE.
- Latency: command accepted at edge E0; completion registered at edge E3. out_valid is high during the cycle after E3, in which cmd_ready is also 1. Earliest next accept is E4, so throughput is 1 command per 4 cycles.
- Hazards: commands are fully serialised, so a command always reads the results of all earlier commands. raa==rab==wa is legal.
- Input stability: cmd_* and Inport are sampled only at the accept edge; later changes are ignored.
- Reset mid-operation: the in-flight command is discarded with no register write and no out_valid. All register contents are cleared per the reset rule.
- Outport holds its value between completions.
- Address wrap: addresses are taken modulo depth (full-width decode, no out-of-range case).

Test Plan:
- Reset then idle: RSTn=0 for 2 cycles → Outport=0, out_valid=0, Zero=0, Carry=0, cmd_ready=0. After release → cmd_ready=1.
- LOAD R1=0x0F, LOAD R2=0xF1, ADD R3=R1+R2 shift none → Outport=0x00, Zero=1, Carry=1. out_valid pulses 3 edges after each accept.
- SUB R4=R1−R2 (0x0F−0xF1) → Outport=0x1E, Carry=1, Zero=0. SUB R5=R2−R1 → 0xE2, Carry=0.
- Shifts on R2=0xF1 via PASS: SHL1 → 0xE2; SHR1 → 0x78; ROR1 → 0xF8. Carry=0 for all three.
- Handshake: hold cmd_valid=1 with back-to-back commands → exactly one accept per 4 cycles, cmd_ready low in READ/EXEC/WRITE. NOP → no out_valid and Outport unchanged.
- Reset asserted in EXEC of "LOAD R6=0xAA" → no out_valid; afterwards PASS R6 reads 0x00.
